// File: rtl/render_line_pkg.sv
// render_line_pkg: shared OAM field layout, sprite geometry, line width default and FSM states
// Ports: none (package).
package render_line_pkg;
   localparam int SPR_SIZE       = 16;
   localparam int PIX_W          = 4;
   localparam int LINE_WIDTH_DEF = 640;
   localparam int OAM_REF_LSB    = 0;
   localparam int OAM_X_LSB      = 8;
   localparam int OAM_Y_LSB      = 18;
   localparam int OAM_PRI        = 28;
   localparam int OAM_XFLIP      = 29;
   localparam int OAM_YFLIP      = 30;
   localparam int OAM_EN         = 31;
   typedef enum logic [2:0] {IDLE, CLEAR, SCAN, OAM_RD, SPR_RD, DRAW, DONE} state_t;
endpackage

// File: rtl/render_line_sprite_row_mux.sv
// sprite_row_mux: picks one 4-bit pixel out of a 16-pixel sprite row, optionally mirrored
// Ports: row (16 packed pixels, pixel p at [4p+3:4p]), p (pixel counter), flip (x-flip), nib (selected pixel)
module sprite_row_mux
   import render_line_pkg::*;
(
   input  logic [SPR_SIZE*PIX_W-1:0] row,
   input  logic [3:0]                p,
   input  logic                      flip,
   output logic [PIX_W-1:0]          nib
);
   logic [3:0] sel;
   always_comb begin
      sel = flip ? 4'(SPR_SIZE - 1) - p : p;
      nib = row[sel*PIX_W +: PIX_W];
   end
endmodule

// File: rtl/render_line.sv
// render_line: renders up to maxObjectPerLine sprites of one scanline into a line buffer
// Ports: clk/reset (async, active high); BufferArray slots {OAM index, valid}; line_prepeared starts a
//        line on its rising edge; sy current line; oam_addr/oam_data OAM read port; sprite_addr/sprite_data
//        sprite row read port; lb_we/lb_addr/lb_data registered line-buffer write; render_done line finished
module render_line
   import render_line_pkg::*;
#(
   parameter int maxObjectPerLine = 32,
   parameter int LineWidth        = LINE_WIDTH_DEF
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic [9*maxObjectPerLine-1:0] BufferArray,
   input  logic                          line_prepeared,
   input  logic [9:0]                    sy,
   output logic [7:0]                    oam_addr,
   input  logic [31:0]                   oam_data,
   output logic [11:0]                   sprite_addr,
   input  logic [63:0]                   sprite_data,
   output logic                          lb_we,
   output logic [9:0]                    lb_addr,
   output logic [4:0]                    lb_data,
   output logic                          render_done
);
   localparam int IW = $clog2(maxObjectPerLine);
   localparam logic [IW-1:0] TOP_IDX = IW'(maxObjectPerLine - 1);
   state_t state, state_n;
   logic lp_q, rise, abort;
   logic [9:0] clr_cnt;
   logic [IW-1:0] idx;
   logic [3:0] pix;
   logic [8:0] slot;
   logic [9:0] x_q, dy;
   logic pri_q, xf_q, show_q;
   logic [63:0] row_q;
   logic [3:0] row, nib;
   logic [10:0] px;
   logic we_n;
   logic [9:0] addr_n;
   logic [4:0] data_n;
   sprite_row_mux u_mux (.row(row_q), .p(pix), .flip(xf_q), .nib(nib));
   always_comb begin
      slot   = BufferArray[idx*9 +: 9];
      rise   = line_prepeared && !lp_q;
      abort  = !line_prepeared && state != IDLE && state != DONE;
      dy     = sy - oam_data[OAM_Y_LSB +: 10];
      row    = oam_data[OAM_YFLIP] ? ~dy[3:0] : dy[3:0];
      px     = {1'b0, x_q} + {7'd0, pix};
      state_n = state;
      we_n    = 1'b0;
      addr_n  = lb_addr;
      data_n  = lb_data;
      case (state)
         IDLE, DONE: state_n = rise ? CLEAR : state;
         CLEAR: begin
            we_n    = 1'b1;
            addr_n  = clr_cnt;
            data_n  = '0;
            state_n = (clr_cnt == 10'(LineWidth - 1)) ? SCAN : CLEAR;
         end
         SCAN:   state_n = slot[0] ? OAM_RD : (idx == '0) ? DONE : SCAN;
         OAM_RD: state_n = SPR_RD;
         SPR_RD: state_n = DRAW;
         DRAW: begin
            // Transparent pixels and anything past the right edge are skipped, never wrapped.
            we_n    = show_q && nib != '0 && px < 11'(LineWidth);
            addr_n  = px[9:0];
            data_n  = {pri_q, nib};
            state_n = (pix == 4'hF) ? ((idx == '0) ? DONE : SCAN) : DRAW;
         end
         default: state_n = IDLE;
      endcase
      if (abort) begin
         state_n = IDLE;
         we_n    = 1'b0;
      end
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= state_n;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         // lp_q starts high so a line_prepeared already high at release is not taken as a new line.
         lp_q        <= 1'b1;
         clr_cnt     <= '0;
         idx         <= '0;
         pix         <= '0;
         x_q         <= '0;
         pri_q       <= 1'b0;
         xf_q        <= 1'b0;
         show_q      <= 1'b0;
         row_q       <= '0;
         oam_addr    <= '0;
         sprite_addr <= '0;
         lb_we       <= 1'b0;
         lb_addr     <= '0;
         lb_data     <= '0;
         render_done <= 1'b0;
      end else begin
         lp_q        <= line_prepeared;
         lb_we       <= we_n;
         lb_addr     <= addr_n;
         lb_data     <= data_n;
         // Raised one cycle into DONE so the final pixel write has already left.
         render_done <= state == DONE && state_n == DONE;
         clr_cnt     <= (state == CLEAR) ? clr_cnt + 10'd1 : '0;
         pix         <= (state == DRAW) ? pix + 4'd1 : '0;
         if (state == CLEAR)
            idx <= TOP_IDX;
         else if ((state == SCAN && !slot[0]) || (state == DRAW && pix == 4'hF))
            idx <= (idx == '0) ? idx : idx - 1'b1;
         if (state == SCAN && slot[0])
            oam_addr <= slot[8:1];
         if (state == OAM_RD) begin
            x_q         <= oam_data[OAM_X_LSB +: 10];
            pri_q       <= oam_data[OAM_PRI];
            xf_q        <= oam_data[OAM_XFLIP];
            show_q      <= oam_data[OAM_EN] && dy[9:4] == '0;
            sprite_addr <= {oam_data[OAM_REF_LSB +: 8], row};
         end
         if (state == SPR_RD)
            row_q <= sprite_data;
      end
endmodule

// File: doc/render_line.md
RENDER_LINE -- requirements
Module: render_line

Interface
REQ-001 Parameters: maxObjectPerLine, default 32, number of sprite-buffer slots; LineWidth, default 640, visible pixels per line.
REQ-002 Ports (clock and reset first):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- BufferArray  in  9 x maxObjectPerLine  per slot: bit0 valid, bits8:1 OAM index.
- line_prepeared  in  1  high while BufferArray is stable for the current line.
- sy  in  10  current line.
- oam_addr  out  8  OAM read address.
- oam_data  in  32  OAM word: [7:0] sprite ref, [17:8] x, [27:18] y, [28] priority, [29] x-flip, [30] y-flip, [31] enable.
- sprite_addr  out  12  {sprite ref, row[3:0]}.
- sprite_data  in  64  16 pixels x 4 bits; pixel p at [4p+3:4p].
- lb_we  out  1  line-buffer write strobe.
- lb_addr  out  10  line-buffer pixel address.
- lb_data  out  5  {priority, colour index[3:0]}.
- render_done  out  1  line fully rendered.

Function
REQ-003 States: IDLE, CLEAR, SCAN, OAM_RD, SPR_RD, DRAW, DONE.
REQ-004 IDLE -> CLEAR on the first cycle line_prepeared is seen high after being low (rising edge); render_done cleared on this transition.
REQ-005 CLEAR: one write per cycle, lb_addr 0..LineWidth-1, lb_data 0, lb_we 1; after address LineWidth-1 -> SCAN with slot index = maxObjectPerLine-1.
REQ-006 SCAN: slot valid -> OAM_RD with oam_addr = slot bits8:1; slot invalid -> decrement index; invalid at index 0 -> DONE; one slot examined per cycle.
REQ-007 Slots processed from highest index down to 0 so that slot 0 is written last and wins overlaps.
REQ-008 OAM_RD: oam_data valid one cycle after oam_addr; latch x, priority, flips, sprite ref; row = (sy - y)[3:0], replaced by 15-row when y-flip set; -> SPR_RD.
REQ-009 SPR_RD: drive sprite_addr; sprite_data valid one cycle later and latched; -> DRAW.
REQ-010 DRAW: 16 cycles, pixel counter i = 0..15; source nibble p = i, or 15-i when x-flip set; lb_addr = x + i (11-bit sum).
REQ-011 lb_we asserted in DRAW only when nibble != 0 and x + i < LineWidth; no wrap-around past the line end.
REQ-012 After i = 15: index 0 -> DONE, else decrement index -> SCAN.
REQ-013 DONE: render_done = 1, lb_we = 0; held until the next rising edge of line_prepeared.
REQ-014 line_prepeared falling in any state other than IDLE/DONE: abort to IDLE within one cycle, lb_we = 0 that cycle, render_done stays 0.
REQ-015 All-invalid BufferArray: CLEAR then DONE after maxObjectPerLine SCAN cycles, no DRAW writes.
REQ-016 Worst case (all slots valid) latency from start to render_done = LineWidth + 19 x maxObjectPerLine cycles, +/-1.
REQ-017 Outputs registered; no combinational path from any input to lb_we, lb_addr or lb_data.

Reset
REQ-018 reset asynchronously forces IDLE; oam_addr, sprite_addr, lb_we, lb_addr, lb_data, render_done = 0; all counters and latches = 0.
REQ-019 Reset asserted mid-line discards work; after release the block waits for a fresh rising edge of line_prepeared.

Structure
REQ-020 Shared package holds the OAM field offsets, sprite size (16), pixel width (4), LineWidth default and the state enum.
REQ-021 One sub-module, sprite_row_mux: selects nibble p from the 64-bit row, applying x-flip; otherwise flat.

Verification
REQ-022 Slot 0 valid -> OAM 5 {ref 3, x 100, y 10, enable}, sy 12, row-2 data 0x0123456789ABCDEF -> writes at 100..114 with colours F..1, no write at 115 (nibble 0).
REQ-023 Same sprite with x-flip -> writes at 101..115 with colours 1..F, no write at 100.
REQ-024 y 10, sy 12, y-flip -> sprite_addr = {3, 4'd13}.
REQ-025 x 630 -> writes only at 630..639; lb_addr never >= 640.
REQ-026 Slots 0 and 1 overlap at x 200 with non-zero pixels -> last write to 200 carries slot 0 colour.
REQ-027 line_prepeared dropped mid-DRAW -> lb_we 0 next cycle, state IDLE, render_done 0; reset mid-CLEAR -> all outputs 0 immediately.
